inst_fetch_queue: RTL

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues SRAM-like reads from the PC and buffers {pc, inst} for decode.
// Latency: data_ok in cycle N gives out_valid in cycle N+1; with IFQ_BYPASS_EN an empty queue presents it in cycle N.
// Backpressure: out_ready=0 fills the buffer, and req drops once in-flight plus buffered entries reach FIFO_DEPTH.

// Generic FIFO with synchronous flush; head_dat shows the oldest entry while count != 0.
// Latency: a push is visible at head one cycle later.
// Backpressure: none internally; callers must not push when full or pop when empty.
module ifq_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop_vld,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + AW'(1);
            if (pop_vld)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_vld) - (AW+1)'(pop_vld);
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module inst_fetch_queue #(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        out_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_ent_t;

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;
    logic [31:0]   infl_pc;
    logic          accept;
    logic          resp;
    logic          keep;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    fetch_ent_t    fifo_in;
    fetch_ent_t    fifo_head;

    assign wr    = 1'b0;
    assign size  = 2'b10;
    assign wstrb = 4'b0;
    assign wdata = 32'b0;
    assign addr  = pc;

    // Outstanding counts every bus transaction still owed a response, including ones marked for discard.
    assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count};
    assign req = !reset && !redirect_valid
               && (outstanding < CW'(MAX_OUTSTANDING))
               && (occupancy < (CW+1)'(FIFO_DEPTH));

    assign accept     = req && addr_ok;
    assign resp       = data_ok && !reset;
    assign keep       = resp && !redirect_valid && (discard_cnt == '0);
    assign fifo_empty = (fifo_count == '0);

    assign fifo_in.pc   = infl_pc;
    assign fifo_in.inst = rdata;

`ifdef IFQ_BYPASS_EN
    logic bypass_vld;
    assign bypass_vld = fifo_empty && keep;
    assign fifo_push  = keep && !(bypass_vld && out_ready);
    assign out_valid  = !reset && (!fifo_empty || bypass_vld);
    assign out_pc     = fifo_empty ? infl_pc : fifo_head.pc;
    assign out_inst   = fifo_empty ? rdata   : fifo_head.inst;
`else
    assign fifo_push  = keep;
    assign out_valid  = !reset && !fifo_empty;
    assign out_pc     = fifo_head.pc;
    assign out_inst   = fifo_head.inst;
`endif

    assign fifo_pop = out_valid && out_ready && !fifo_empty && !redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            discard_cnt <= '0;
        end else if (redirect_valid) begin
            // No request is accepted in a redirect cycle, so everything left in flight becomes a discard.
            pc          <= redirect_pc;
            discard_cnt <= outstanding - CW'(resp);
        end else begin
            if (accept) pc <= pc + 32'd4;
            if (resp && discard_cnt != '0) discard_cnt <= discard_cnt - CW'(1);
        end
    end

    // The in-flight PC queue's occupancy doubles as the outstanding counter.
    ifq_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_infl_q (
        .clk      (clk),
        .reset    (reset),
        .flush    (1'b0),
        .push_vld (accept),
        .push_dat (pc),
        .pop_vld  (resp),
        .head_dat (infl_pc),
        .count    (outstanding)
    );

    ifq_fifo #(
        .W     ($bits(fetch_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_q (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push_vld (fifo_push),
        .push_dat (fifo_in),
        .pop_vld  (fifo_pop),
        .head_dat (fifo_head),
        .count    (fifo_count)
    );
endmodule
